deserializer_8b: RTL and testbench
==================================

DESERIALIZER_8B -- requirements
Module: deserializer_8b

Interface
REQ-001: The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst as elsewhere in the codebase.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst  input  1  asynchronous active-high reset; forces the reset state immediately, independent of clk.
REQ-004: start  input  1  request to begin receiving one byte.
REQ-005: in_val  input  1  in_bit is valid this cycle.
REQ-006: in_bit  input  1  serial data bit, LSB first.
REQ-007: busy  output  1  high while a byte is being received (RECV state).
REQ-008: out_val  output  1  one-cycle pulse marking a new complete byte; drives the downstream 8-bit register enable directly.
REQ-009: out_data  output  8  last completed byte; drives the downstream 8-bit register data input directly.
REQ-010: All outputs SHALL be registered (Moore); no combinational path from any input to any output.

Function
REQ-011: The FSM SHALL have exactly three states: IDLE, RECV, DONE.
REQ-012: IDLE: busy=0, out_val=0; start=1 at an edge -> RECV with bit count cleared to 0; otherwise stay in IDLE.
REQ-013: The edge that accepts start SHALL NOT capture in_bit, even if in_val=1 in that cycle.
REQ-014: IDLE: in_val and in_bit are ignored.
REQ-015: RECV: busy=1; at each edge with in_val=1, in_bit is written to shift bit [count] and the 3-bit count increments.
REQ-016: RECV: edges with in_val=0 change nothing; gaps of any length are allowed.
REQ-017: RECV: the edge capturing the 8th bit (count=7, in_val=1) SHALL copy the assembled byte to out_data and go to DONE; count wraps to 0.
REQ-018: RECV: start is ignored; no restart or abort mid-byte.
REQ-019: DONE: out_val=1 for exactly one cycle and busy=0; the next edge goes to RECV if start=1 (back-to-back), else IDLE.
REQ-020: DONE: in_val is ignored; a start edge in DONE follows REQ-013.
REQ-021: out_data SHALL change only on the RECV->DONE edge; partial bytes are never visible, and the previous byte is held until the next byte completes.
REQ-022: Latency: out_val SHALL be high in the cycle immediately after the edge that captured bit 7.

Reset
REQ-023: While rst=1: state=IDLE, count=0, shift register=0x00, out_data=0x00, out_val=0, busy=0.
REQ-024: Reset during RECV or DONE SHALL discard the partial byte and any pending pulse; no out_val may appear due to pre-reset bits.
REQ-025: After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-026: Reset -> out_data=0x00, out_val=0, busy=0. Then start; bits 1,0,1,0,0,1,0,1 on 8 consecutive edges -> out_data=0xA5, out_val high exactly one cycle, in the cycle after the 8th bit edge.
REQ-027: Same 0xA5 byte with in_val low for 1-3 cycles between bits -> out_data=0xA5, one pulse, busy high throughout.
REQ-028: in_val=1 while IDLE, and start=1 pulsed mid-RECV -> IDLE bits are not captured, the byte is not restarted, result is still 0xA5.
REQ-029: start held high during the DONE cycle of 0xA5, then 0x3C sent -> no IDLE cycle between bytes; out_data stays 0xA5 until the 0x3C pulse.
REQ-030: rst asserted asynchronously (mid-cycle) after 3 bits of a byte -> outputs reset immediately with no pulse; a following full byte 0x5A completes correctly.
REQ-031: out_val/out_data wired to the downstream 8-bit register en/d over the sequences above -> register holds each byte from the edge after its pulse, and is unchanged otherwise.

Source files
------------

// File: rtl/deserializer_8b_if.sv
// Handshake bundle for the 8-bit serial-to-parallel receiver: request/bit
// inputs toward the receiver, status and completed byte back out.
interface deserializer_8b_if;
  logic       start;
  logic       in_val;
  logic       in_bit;
  logic       busy;
  logic       out_val;
  logic [7:0] out_data;

  modport master (
    output start, in_val, in_bit,
    input  busy, out_val, out_data
  );

  modport slave (
    input  start, in_val, in_bit,
    output busy, out_val, out_data
  );
endinterface

// File: rtl/deserializer_8b.sv
// Collects eight LSB-first serial bits into a byte and presents it with a
// one-cycle valid pulse; all outputs are registered.
module deserializer_8b (
  input logic               clk,
  input logic               rst,
  deserializer_8b_if.slave  bus
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [2:0]          count;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   data_q;
  logic                vld_q;
  logic                busy_q;

  assign bus.busy     = busy_q;
  assign bus.out_val  = vld_q;
  assign bus.out_data = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 3'd0;
      shift  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_q <= 1'b0;
          if (bus.start) begin
            state  <= RECV;
            count  <= 3'd0;
            busy_q <= 1'b1;
          end
        end

        RECV: begin
          vld_q <= 1'b0;
          if (bus.in_val) begin
            shift[count] <= bus.in_bit;
            count        <= count + 3'd1;
            // Final bit goes straight into the output byte so it is complete
            // in the same edge that leaves RECV.
            if (count == 3'd7) begin
              data_q <= {bus.in_bit, shift[6:0]};
              vld_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          vld_q <= 1'b0;
          if (bus.start) begin
            state  <= RECV;
            count  <= 3'd0;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          count  <= 3'd0;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_8b.sv
// Directed plus randomized bench for deserializer_8b with a bit-list
// reference model and a downstream enable register.
module tb_deserializer_8b;

  logic clk;
  logic rst;
  deserializer_8b_if bus ();

  deserializer_8b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register fed directly by out_val/out_data.
  logic [7:0] dreg;
  initial dreg = 8'h00;
  always @(posedge clk) if (bus.out_val) dreg <= bus.out_data;

  int         errors;
  int         checks;
  logic [7:0] last_byte;     // model: last completed byte seen at out_data
  logic [7:0] exp_reg;       // model: downstream register contents
  bit         pulse_pending;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (pulse_pending) begin
      exp_reg       = last_byte;
      pulse_pending = 1'b0;
    end
    #1;
  endtask

  function automatic logic [7:0] assemble(input bit b[8]);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) if (b[i]) v = v + (1 << i);
    return v[7:0];
  endfunction

  // Starts a byte (from IDLE or DONE) and sends the bits with random gaps.
  // Returns in the cycle where out_val is expected high.
  task automatic send_bits(input bit b[8], input int gmin, input int gmax, input bit noise);
    logic [7:0] expb;
    int         g;
    expb       = assemble(b);
    bus.start  = 1'b1;
    bus.in_val = noise;
    bus.in_bit = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.in_val = 1'b0;
    check("accept_busy", {7'd0, bus.busy}, 8'd1);
    check("accept_noval", {7'd0, bus.out_val}, 8'd0);
    check("accept_hold", bus.out_data, last_byte);
    for (int i = 0; i < 8; i++) begin
      g = $urandom_range(gmax, gmin);
      for (int k = 0; k < g; k++) begin
        bus.in_val = 1'b0;
        bus.in_bit = ($urandom_range(0, 1) == 1);
        bus.start  = noise && ($urandom_range(0, 1) == 1);
        tick();
        check("gap_busy", {7'd0, bus.busy}, 8'd1);
        check("gap_noval", {7'd0, bus.out_val}, 8'd0);
      end
      bus.in_val = 1'b1;
      bus.in_bit = b[i];
      bus.start  = noise && ($urandom_range(0, 1) == 1);
      tick();
      bus.in_val = 1'b0;
      bus.start  = 1'b0;
      if (i < 7) begin
        check("bit_busy", {7'd0, bus.busy}, 8'd1);
        check("bit_noval", {7'd0, bus.out_val}, 8'd0);
        check("bit_hold", bus.out_data, last_byte);
        check("dreg_hold", dreg, exp_reg);
      end
    end
    check("done_val", {7'd0, bus.out_val}, 8'd1);
    check("done_busy", {7'd0, bus.busy}, 8'd0);
    check("done_data", bus.out_data, expb);
    last_byte     = expb;
    pulse_pending = 1'b1;
  endtask

  task automatic idle_cycle(input string tag);
    bus.start  = 1'b0;
    bus.in_val = ($urandom_range(0, 1) == 1);
    bus.in_bit = ($urandom_range(0, 1) == 1);
    tick();
    check({tag, "_noval"}, {7'd0, bus.out_val}, 8'd0);
    check({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    check({tag, "_data"}, bus.out_data, last_byte);
    check({tag, "_dreg"}, dreg, exp_reg);
  endtask

  bit bits_a5[8];
  bit bits_3c[8];
  bit bits_5a[8];
  bit bits_r[8];

  initial begin
    errors        = 0;
    checks        = 0;
    last_byte     = 8'h00;
    exp_reg       = 8'h00;
    pulse_pending = 1'b0;
    bits_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
    bits_3c = '{0, 0, 1, 1, 1, 1, 0, 0};
    bits_5a = '{0, 1, 0, 1, 1, 0, 1, 0};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.in_val = 1'b0;
    bus.in_bit = 1'b0;
    #2;
    check("rst_data", bus.out_data, 8'h00);
    check("rst_val", {7'd0, bus.out_val}, 8'd0);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    tick();
    tick();
    #2 rst = 1'b0;

    // IDLE ignores serial traffic.
    for (int i = 0; i < 4; i++) idle_cycle("idle_noise");

    // Plain 0xA5, no gaps.
    send_bits(bits_a5, 0, 0, 1'b0);
    idle_cycle("a5_after");
    idle_cycle("a5_after2");

    // 0xA5 with 1-3 cycle gaps.
    send_bits(bits_a5, 1, 3, 1'b0);
    idle_cycle("gap_after");

    // IDLE bits then start with in_val high, start pulsed mid-byte.
    for (int i = 0; i < 3; i++) idle_cycle("pre_noise");
    send_bits(bits_a5, 0, 2, 1'b1);
    idle_cycle("noise_after");

    // Back-to-back: start held in DONE, then 0x3C.
    send_bits(bits_a5, 0, 0, 1'b0);
    bus.in_val = 1'b1;
    send_bits(bits_3c, 0, 1, 1'b1);
    idle_cycle("b2b_after");
    check("b2b_dreg", dreg, 8'h3C);

    // Asynchronous reset after three bits of a byte.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_val = 1'b1;
      bus.in_bit = ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.in_val = 1'b0;
    #2 rst = 1'b1;
    #1;
    last_byte = 8'h00;
    check("arst_data", bus.out_data, 8'h00);
    check("arst_val", {7'd0, bus.out_val}, 8'd0);
    check("arst_busy", {7'd0, bus.busy}, 8'd0);
    bus.in_val = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    bus.in_val = 1'b0;
    for (int i = 0; i < 5; i++) idle_cycle("post_rst");
    check("post_rst_dreg", dreg, 8'h3C);
    send_bits(bits_5a, 0, 0, 1'b0);
    idle_cycle("5a_after");
    check("5a_dreg", dreg, 8'h5A);

    // Random bytes, random gaps, noise and occasional back-to-back.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 8; i++) bits_r[i] = ($urandom_range(0, 1) == 1);
      send_bits(bits_r, 0, 3, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) != 0) idle_cycle("rand_after");
    end
    idle_cycle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
